// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the memory-access pipeline stage.
//   - bundle widths for the execute-side input, exception and write-back bundles
//   - bit offsets of the fields packed inside the ctrl word of the input bundle
//   - access-size encodings driven on data_sram_size
//   - request FSM state encoding
//   - req_size(): maps the byte/half access flags onto a size encoding
package mem_stage_pkg;

    localparam int IN_W   = 145;
    localparam int EXC_W  = 87;
    localparam int OUT_W  = 103;
    localparam int CTRL_W = 48;

    // ctrl = {ld_b, ld_bu, ld_h, ld_hu, ld_w, st_b, st_h, st_w,
    //         mem_we, res_from_mem, gr_we, rkd_value[32], rf_waddr[5]}
    localparam int CTRL_WADDR_LSB = 0;
    localparam int CTRL_RKD_LSB   = 5;
    localparam int CTRL_GR_WE     = 37;
    localparam int CTRL_RES_MEM   = 38;
    localparam int CTRL_MEM_WE    = 39;
    localparam int CTRL_ST_W      = 40;
    localparam int CTRL_ST_H      = 41;
    localparam int CTRL_ST_B      = 42;
    localparam int CTRL_LD_W      = 43;
    localparam int CTRL_LD_HU     = 44;
    localparam int CTRL_LD_H      = 45;
    localparam int CTRL_LD_BU     = 46;
    localparam int CTRL_LD_B      = 47;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Word is the fallback so that a non-memory op never yields a narrow size.
    function automatic logic [1:0] req_size(input logic is_byte, input logic is_half);
        logic [1:0] size;
        if (is_byte) begin
            size = SIZE_B;
        end else if (is_half) begin
            size = SIZE_H;
        end else begin
            size = SIZE_W;
        end
        return size;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: SRAM-like data request/response bus.
//   master (memory stage): drives req, wr, size, wstrb, addr, wdata;
//                          samples addr_ok, data_ok, rdata.
//   slave  (memory/bridge): the mirror image.
interface mem_stage_if;

    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );

    modport slave (
        input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );

endinterface

// File: rtl/mem_align.sv
// mem_align: purely combinational byte-lane logic for the memory stage.
//   size      in  access size (SIZE_B/H/W)
//   is_st     in  access is a store (strobes are zero for loads)
//   sign_ext  in  load result is sign-extended (ld_b / ld_h)
//   addr_lo   in  low two address bits
//   rkd       in  store source register value
//   rdata     in  loaded word
//   wstrb     out byte strobes for the store
//   wdata     out store data replicated onto every lane it may land in
//   load_data out selected and extended load result
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_st,
    input  logic        sign_ext,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rkd,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store strobes and lane-replicated write data.
    always_comb begin
        wstrb = 4'b0000;
        wdata = rkd;
        if (is_st) begin
            case (size)
                SIZE_B: begin
                    wstrb = 4'b0001 << addr_lo;
                    wdata = {4{rkd[7:0]}};
                end
                SIZE_H: begin
                    wstrb = 4'b0011 << {addr_lo[1], 1'b0};
                    wdata = {2{rkd[15:0]}};
                end
                SIZE_W: begin
                    wstrb = 4'b1111;
                    wdata = rkd;
                end
                default: begin
                    wstrb = 4'b0000;
                    wdata = rkd;
                end
            endcase
        end else begin
            wstrb = 4'b0000;
            wdata = rkd;
        end
    end

    // Load lane select followed by sign or zero extension.
    always_comb begin
        byte_s    = rdata[7:0];
        half_s    = rdata[15:0];
        load_data = rdata;
        case (addr_lo)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        if (addr_lo[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (size)
            SIZE_B:  load_data = {{24{sign_ext & byte_s[7]}}, byte_s};
            SIZE_H:  load_data = {{16{sign_ext & half_s[15]}}, half_s};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and write-back.
//   clk, rst         clock; asynchronous active-high reset
//   WB_allowin       write-back can accept
//   flush            kills the instruction currently held in this stage
//   EX_to_MEM_zip    {valid, pc, ir, ctrl, alu_result} from execute
//   EX_except_zip    exception bundle from execute (bit 0 = misaligned)
//   MEM_allowin      this stage can accept a new instruction
//   sram             data SRAM-like request/response bus (master side)
//   front_*          forwarding value and load-use stall hint for decode
//   MEM_to_WB_reg    registered {valid, pc, ir, gr_we, rf_waddr, result}
//   MEM_except_reg   registered exception bundle
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               WB_allowin,
    input  logic               flush,
    input  logic [IN_W-1:0]    EX_to_MEM_zip,
    input  logic [EXC_W-1:0]   EX_except_zip,
    output logic               MEM_allowin,
    mem_stage_if.master        sram,
    output logic               front_valid,
    output logic               front_stall,
    output logic [4:0]         front_addr,
    output logic [31:0]        front_data,
    output logic [OUT_W-1:0]   MEM_to_WB_reg,
    output logic [EXC_W-1:0]   MEM_except_reg
);

    logic              zip_valid_s;
    logic [31:0]       pc_s, ir_s, alu_s, rkd_s;
    logic [CTRL_W-1:0] ctrl_s;
    logic [4:0]        waddr_s;
    logic ld_b_s, ld_bu_s, ld_h_s, ld_hu_s, ld_w_s, st_b_s, st_h_s, st_w_s;
    logic mem_we_s, res_mem_s, gr_we_s;
    logic is_ld_s, is_st_s, is_mem_s, has_exc_s, valid_s, readygo_s, issue_s;
    logic [1:0]  size_s;
    logic [3:0]  wstrb_s;
    logic [31:0] wdata_s, load_data_s, result_s;
    logic        unused_s;

    state_t            state_q, state_d;
    logic              cancel_q, cancel_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              req_wr_q, req_wr_d;
    logic [1:0]        req_size_q, req_size_d;
    logic [3:0]        req_wstrb_q, req_wstrb_d;
    logic [31:0]       req_addr_q, req_addr_d;
    logic [31:0]       req_wdata_q, req_wdata_d;
    logic [OUT_W-1:0]  wb_q, wb_d;
    logic [EXC_W-1:0]  exc_q, exc_d;

    assign {zip_valid_s, pc_s, ir_s, ctrl_s, alu_s} = EX_to_MEM_zip;
    assign waddr_s   = ctrl_s[CTRL_WADDR_LSB +: 5];
    assign rkd_s     = ctrl_s[CTRL_RKD_LSB +: 32];
    assign gr_we_s   = ctrl_s[CTRL_GR_WE];
    assign res_mem_s = ctrl_s[CTRL_RES_MEM];
    assign mem_we_s  = ctrl_s[CTRL_MEM_WE];
    assign st_w_s    = ctrl_s[CTRL_ST_W];
    assign st_h_s    = ctrl_s[CTRL_ST_H];
    assign st_b_s    = ctrl_s[CTRL_ST_B];
    assign ld_w_s    = ctrl_s[CTRL_LD_W];
    assign ld_hu_s   = ctrl_s[CTRL_LD_HU];
    assign ld_h_s    = ctrl_s[CTRL_LD_H];
    assign ld_bu_s   = ctrl_s[CTRL_LD_BU];
    assign ld_b_s    = ctrl_s[CTRL_LD_B];
    // mem_we duplicates the st_* flags; the request direction is taken from those.
    assign unused_s  = mem_we_s;

    assign is_ld_s   = ld_b_s | ld_bu_s | ld_h_s | ld_hu_s | ld_w_s;
    assign is_st_s   = st_b_s | st_h_s | st_w_s;
    assign is_mem_s  = is_ld_s | is_st_s;
    assign has_exc_s = |EX_except_zip;
    assign valid_s   = zip_valid_s & ~flush;
    assign size_s    = req_size(ld_b_s | ld_bu_s | st_b_s, ld_h_s | ld_hu_s | st_h_s);

    mem_align u_align (
        .size      (size_s),
        .is_st     (is_st_s),
        .sign_ext  (ld_b_s | ld_h_s),
        .addr_lo   (alu_s[1:0]),
        .rkd       (rkd_s),
        .rdata     (rdata_q),
        .wstrb     (wstrb_s),
        .wdata     (wdata_s),
        .load_data (load_data_s)
    );

    assign result_s = res_mem_s ? load_data_s : alu_s;

    // Request FSM: issue, hold until accepted, wait for the response, and
    // drain a response whose instruction was flushed so it never reaches a younger one.
    always_comb begin
        state_d  = state_q;
        cancel_d = cancel_q;
        rdata_d  = rdata_q;
        issue_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_s & is_mem_s & ~has_exc_s) begin
                    state_d = ST_REQ;
                    issue_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (flush) begin
                    cancel_d = 1'b1;
                end else begin
                    cancel_d = cancel_q;
                end
                if (sram.data_sram_addr_ok) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (sram.data_sram_data_ok) begin
                    // A flush in the same cycle as the response needs no cancel:
                    // the response is consumed here and discarded.
                    if (cancel_q | flush) begin
                        state_d  = ST_IDLE;
                        cancel_d = 1'b0;
                    end else begin
                        state_d = ST_DONE;
                        rdata_d = sram.data_sram_rdata;
                    end
                end else if (flush) begin
                    cancel_d = 1'b1;
                end else begin
                    cancel_d = cancel_q;
                end
            end
            ST_DONE: begin
                if (WB_allowin | flush) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                cancel_d = 1'b0;
            end
        endcase
    end

    // Request attributes are latched at issue so they stay stable while the
    // request is held, even if a flush lets a new instruction in meanwhile.
    always_comb begin
        req_wr_d    = req_wr_q;
        req_size_d  = req_size_q;
        req_wstrb_d = req_wstrb_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        if (issue_s) begin
            req_wr_d    = is_st_s;
            req_size_d  = size_s;
            req_wstrb_d = wstrb_s;
            req_addr_d  = alu_s;
            req_wdata_d = wdata_s;
        end else begin
            req_wr_d    = req_wr_q;
        end
    end

    assign readygo_s   = (state_q == ST_DONE)
                       | ((state_q == ST_IDLE) & valid_s & (~is_mem_s | has_exc_s))
                       | flush;
    assign MEM_allowin = ~valid_s | (readygo_s & WB_allowin);

    // Write-back bundle: capture on hand-off, insert a bubble when write-back
    // is free but this stage is not ready, otherwise hold.
    always_comb begin
        wb_d  = wb_q;
        exc_d = exc_q;
        if (readygo_s & WB_allowin) begin
            wb_d  = {valid_s, pc_s, ir_s, gr_we_s & ~has_exc_s, waddr_s, result_s};
            exc_d = EX_except_zip;
        end else if (WB_allowin) begin
            wb_d  = '0;
            exc_d = '0;
        end else begin
            wb_d  = wb_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cancel_q    <= 1'b0;
            rdata_q     <= 32'd0;
            req_wr_q    <= 1'b0;
            req_size_q  <= 2'd0;
            req_wstrb_q <= 4'd0;
            req_addr_q  <= 32'd0;
            req_wdata_q <= 32'd0;
            wb_q        <= '0;
            exc_q       <= '0;
        end else begin
            state_q     <= state_d;
            cancel_q    <= cancel_d;
            rdata_q     <= rdata_d;
            req_wr_q    <= req_wr_d;
            req_size_q  <= req_size_d;
            req_wstrb_q <= req_wstrb_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            wb_q        <= wb_d;
            exc_q       <= exc_d;
        end
    end

    assign sram.data_sram_req   = (state_q == ST_REQ);
    assign sram.data_sram_wr    = req_wr_q;
    assign sram.data_sram_size  = req_size_q;
    assign sram.data_sram_wstrb = req_wstrb_q;
    assign sram.data_sram_addr  = req_addr_q;
    assign sram.data_sram_wdata = req_wdata_q;

    assign front_valid    = valid_s & gr_we_s & (~res_mem_s | (state_q == ST_DONE));
    assign front_stall    = valid_s & gr_we_s & res_mem_s & (state_q != ST_DONE);
    assign front_addr     = waddr_s;
    assign front_data     = result_s;
    assign MEM_to_WB_reg  = wb_q;
    assign MEM_except_reg = exc_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             WB_allowin;
    logic             flush;
    logic [IN_W-1:0]  EX_to_MEM_zip;
    logic [EXC_W-1:0] EX_except_zip;
    logic             MEM_allowin;
    logic             front_valid, front_stall;
    logic [4:0]       front_addr;
    logic [31:0]      front_data;
    logic [OUT_W-1:0] MEM_to_WB_reg;
    logic [EXC_W-1:0] MEM_except_reg;

    mem_stage_if sram();

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .WB_allowin     (WB_allowin),
        .flush          (flush),
        .EX_to_MEM_zip  (EX_to_MEM_zip),
        .EX_except_zip  (EX_except_zip),
        .MEM_allowin    (MEM_allowin),
        .sram           (sram),
        .front_valid    (front_valid),
        .front_stall    (front_stall),
        .front_addr     (front_addr),
        .front_data     (front_data),
        .MEM_to_WB_reg  (MEM_to_WB_reg),
        .MEM_except_reg (MEM_except_reg)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // op codes used by the bench: 0 add, 1 ld_b, 2 ld_bu, 3 ld_h, 4 ld_hu,
    // 5 ld_w, 6 st_b, 7 st_h, 8 st_w
    localparam int OP_ADD = 0, OP_LDB = 1, OP_LDHU = 4, OP_LDW = 5, OP_STH = 7;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_load(input int op);
        return (op >= 1) && (op <= 5);
    endfunction

    function automatic logic is_store(input int op);
        return op >= 6;
    endfunction

    function automatic logic [47:0] mk_ctrl(input int op, input logic [31:0] rkd, input logic [4:0] wa);
        return {op == 1, op == 2, op == 3, op == 4, op == 5, op == 6, op == 7, op == 8,
                is_store(op), is_load(op), is_load(op) | (op == 0), rkd, wa};
    endfunction

    function automatic logic [IN_W-1:0] mk_zip(input int op, input logic [31:0] pc, input logic [31:0] ir,
                                               input logic [31:0] addr, input logic [31:0] rkd,
                                               input logic [4:0] wa);
        return {1'b1, pc, ir, mk_ctrl(op, rkd, wa), addr};
    endfunction

    function automatic logic [31:0] exp_size(input int op);
        if (op == 1 || op == 2 || op == 6) return 32'd0;
        if (op == 3 || op == 4 || op == 7) return 32'd1;
        return 32'd2;
    endfunction

    function automatic logic [31:0] exp_wstrb(input int op, input logic [31:0] addr);
        if (!is_store(op)) return 32'd0;
        if (exp_size(op) == 32'd0) return 32'd1 << (addr % 32'd4);
        if (exp_size(op) == 32'd1) return 32'd3 << ((addr % 32'd4) / 32'd2 * 32'd2);
        return 32'd15;
    endfunction

    function automatic logic [31:0] exp_wdata(input int op, input logic [31:0] rkd);
        if (exp_size(op) == 32'd0) return (rkd % 32'd256) * 32'h0101_0101;
        if (exp_size(op) == 32'd1) return (rkd % 32'd65536) * 32'h0001_0001;
        return rkd;
    endfunction

    function automatic logic [31:0] exp_load(input int op, input logic [31:0] addr, input logic [31:0] rdata);
        logic [31:0] v;
        v = rdata;
        if (op == 1 || op == 2) begin
            v = (rdata >> (32'd8 * (addr % 32'd4))) % 32'd256;
            if (op == 1 && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (op == 3 || op == 4) begin
            v = (rdata >> (32'd16 * ((addr / 32'd2) % 32'd2))) % 32'd65536;
            if (op == 3 && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          op;
        int          lat;
        logic [31:0] pc, ir, addr, rkd, rd, expv;
        logic [4:0]  wa;
        logic [EXC_W-1:0] exc_v;

        // ---------------- reset ----------------
        rst = 1'b1; flush = 1'b0; WB_allowin = 1'b1; EX_except_zip = '0;
        sram.data_sram_addr_ok = 1'b0; sram.data_sram_data_ok = 1'b0; sram.data_sram_rdata = 32'd0;
        EX_to_MEM_zip = mk_zip(OP_LDW, 32'h100, 32'h200, 32'h0, 32'h0, 5'd1);
        tick(); tick();
        chk1("rst_req", sram.data_sram_req, 1'b0);
        chkw("rst_wb", 128'(MEM_to_WB_reg), 128'd0);
        chkw("rst_exc", 128'(MEM_except_reg), 128'd0);
        EX_to_MEM_zip = '0;
        rst = 1'b0;
        tick();

        // ---------------- ld_b 0x1003 ----------------
        EX_to_MEM_zip = mk_zip(OP_LDB, 32'h1000, 32'hA1, 32'h1003, 32'h0, 5'd5);
        #1;
        chk1("ldb_idle_req", sram.data_sram_req, 1'b0);
        chk1("ldb_allowin0", MEM_allowin, 1'b0);
        chk1("ldb_stall", front_stall, 1'b1);
        chk1("ldb_fv0", front_valid, 1'b0);
        tick();
        chk1("ldb_req", sram.data_sram_req, 1'b1);
        chk32("ldb_addr", sram.data_sram_addr, 32'h1003);
        chk32("ldb_size", 32'(sram.data_sram_size), 32'd0);
        chk1("ldb_wr", sram.data_sram_wr, 1'b0);
        chk32("ldb_wstrb", 32'(sram.data_sram_wstrb), 32'd0);
        sram.data_sram_addr_ok = 1'b1;
        tick();
        sram.data_sram_addr_ok = 1'b0;
        #1;
        chk1("ldb_req_wait", sram.data_sram_req, 1'b0);
        tick();
        chk1("ldb_req_wait2", sram.data_sram_req, 1'b0);
        sram.data_sram_data_ok = 1'b1; sram.data_sram_rdata = 32'h80FF_1234;
        tick();
        sram.data_sram_data_ok = 1'b0;
        #1;
        chk1("ldb_done_fv", front_valid, 1'b1);
        chk1("ldb_done_stall", front_stall, 1'b0);
        chk32("ldb_fdata", front_data, 32'hFFFF_FF80);
        chk32("ldb_faddr", 32'(front_addr), 32'd5);
        chk1("ldb_done_allowin", MEM_allowin, 1'b1);
        chk1("ldb_wb_notyet", MEM_to_WB_reg[OUT_W-1], 1'b0);
        tick();
        chkw("ldb_wb", 128'(MEM_to_WB_reg), 128'({1'b1, 32'h1000, 32'hA1, 1'b1, 5'd5, 32'hFFFF_FF80}));
        EX_to_MEM_zip = '0;
        tick();
        chk1("ldb_wb_once", MEM_to_WB_reg[OUT_W-1], 1'b0);

        // ---------------- st_h 0x2002 ----------------
        EX_to_MEM_zip = mk_zip(OP_STH, 32'h1004, 32'hB2, 32'h2002, 32'h0000_ABCD, 5'd0);
        tick();
        chk1("sth_req", sram.data_sram_req, 1'b1);
        chk32("sth_size", 32'(sram.data_sram_size), 32'd1);
        chk32("sth_wstrb", 32'(sram.data_sram_wstrb), 32'hC);
        chk32("sth_wdata", sram.data_sram_wdata, 32'hABCD_ABCD);
        chk1("sth_wr", sram.data_sram_wr, 1'b1);
        sram.data_sram_addr_ok = 1'b1;
        tick();
        sram.data_sram_addr_ok = 1'b0; sram.data_sram_data_ok = 1'b1;
        tick();
        sram.data_sram_data_ok = 1'b0;
        tick();
        chkw("sth_wb", 128'(MEM_to_WB_reg), 128'({1'b1, 32'h1004, 32'hB2, 1'b0, 5'd0, 32'h2002}));
        EX_to_MEM_zip = '0;

        // ---------------- add (non-memory) ----------------
        EX_to_MEM_zip = mk_zip(OP_ADD, 32'h1008, 32'hC3, 32'h1234_5678, 32'h0, 5'd7);
        #1;
        chk1("add_req", sram.data_sram_req, 1'b0);
        chk1("add_fv", front_valid, 1'b1);
        chk32("add_fdata", front_data, 32'h1234_5678);
        chk32("add_faddr", 32'(front_addr), 32'd7);
        chk1("add_allowin", MEM_allowin, 1'b1);
        tick();
        chkw("add_wb", 128'(MEM_to_WB_reg), 128'({1'b1, 32'h1008, 32'hC3, 1'b1, 5'd7, 32'h1234_5678}));
        chk1("add_req2", sram.data_sram_req, 1'b0);
        EX_to_MEM_zip = '0;

        // ---------------- ld_w with exception ----------------
        exc_v = 87'h12_3456_789A_BCDE_F000_0001;
        EX_to_MEM_zip = mk_zip(OP_LDW, 32'h100C, 32'hD4, 32'h5001, 32'h0, 5'd9);
        EX_except_zip = exc_v;
        #1;
        chk1("exc_req", sram.data_sram_req, 1'b0);
        chk1("exc_allowin", MEM_allowin, 1'b1);
        tick();
        chk1("exc_req2", sram.data_sram_req, 1'b0);
        chkw("exc_bundle", 128'(MEM_except_reg), 128'(exc_v));
        chk32("exc_wb_fields", 32'({MEM_to_WB_reg[OUT_W-1], MEM_to_WB_reg[37], MEM_to_WB_reg[36:32]}),
              32'({1'b1, 1'b0, 5'd9}));
        EX_to_MEM_zip = '0; EX_except_zip = '0;
        tick();
        chk1("exc_req3", sram.data_sram_req, 1'b0);

        // ---------------- flush in WAIT, then ld_hu ----------------
        EX_to_MEM_zip = mk_zip(OP_LDW, 32'h1010, 32'hE5, 32'h3000, 32'h0, 5'd3);
        tick();
        sram.data_sram_addr_ok = 1'b1;
        tick();
        sram.data_sram_addr_ok = 1'b0; flush = 1'b1;
        #1;
        chk1("fl_allowin", MEM_allowin, 1'b1);
        chk1("fl_fv", front_valid, 1'b0);
        tick();
        flush = 1'b0;
        chk1("fl_wb_killed", MEM_to_WB_reg[OUT_W-1], 1'b0);
        EX_to_MEM_zip = mk_zip(OP_LDHU, 32'h1014, 32'hF6, 32'h4000, 32'h0, 5'd4);
        #1;
        chk1("fl_req_held", sram.data_sram_req, 1'b0);
        chk1("fl_allowin0", MEM_allowin, 1'b0);
        chk1("fl_stall", front_stall, 1'b1);
        tick();
        chk1("fl_req_held2", sram.data_sram_req, 1'b0);
        sram.data_sram_data_ok = 1'b1; sram.data_sram_rdata = 32'hDEAD_BEEF;
        tick();
        sram.data_sram_data_ok = 1'b0;
        #1;
        chk1("fl_req_drain", sram.data_sram_req, 1'b0);
        tick();
        chk1("ldhu_req", sram.data_sram_req, 1'b1);
        chk32("ldhu_addr", sram.data_sram_addr, 32'h4000);
        chk32("ldhu_size", 32'(sram.data_sram_size), 32'd1);
        sram.data_sram_addr_ok = 1'b1;
        tick();
        sram.data_sram_addr_ok = 1'b0; sram.data_sram_data_ok = 1'b1; sram.data_sram_rdata = 32'h0000_8001;
        tick();
        sram.data_sram_data_ok = 1'b0; WB_allowin = 1'b0;
        #1;
        // ---------------- write-back stalled in DONE ----------------
        for (int i = 0; i < 4; i++) begin
            chk1("stl_allowin", MEM_allowin, 1'b0);
            chk1("stl_stall", front_stall, 1'b0);
            chk1("stl_fv", front_valid, 1'b1);
            chk32("stl_fdata", front_data, 32'h0000_8001);
            chkw("stl_wb_hold", 128'(MEM_to_WB_reg), 128'd0);
            tick();
        end
        WB_allowin = 1'b1;
        #1;
        chk1("stl_allowin1", MEM_allowin, 1'b1);
        tick();
        chkw("ldhu_wb", 128'(MEM_to_WB_reg), 128'({1'b1, 32'h1014, 32'hF6, 1'b1, 5'd4, 32'h0000_8001}));
        EX_to_MEM_zip = '0;
        tick();

        // ---------------- randomized transactions ----------------
        for (int t = 0; t < 40; t++) begin
            op   = int'($urandom_range(0, 8));
            pc   = $urandom; ir = $urandom; addr = $urandom; rkd = $urandom; rd = $urandom;
            wa   = 5'($urandom_range(1, 31));
            expv = is_load(op) ? exp_load(op, addr, rd) : addr;
            EX_to_MEM_zip = mk_zip(op, pc, ir, addr, rkd, wa);
            #1;
            if (op == OP_ADD) begin
                chk1("rnd_add_fv", front_valid, 1'b1);
                chk32("rnd_add_fdata", front_data, addr);
                tick();
            end else begin
                chk1("rnd_idle_req", sram.data_sram_req, 1'b0);
                tick();
                chk1("rnd_req", sram.data_sram_req, 1'b1);
                chk32("rnd_addr", sram.data_sram_addr, addr);
                chk1("rnd_wr", sram.data_sram_wr, is_store(op));
                chk32("rnd_size", 32'(sram.data_sram_size), exp_size(op));
                chk32("rnd_wstrb", 32'(sram.data_sram_wstrb), exp_wstrb(op, addr));
                if (is_store(op)) chk32("rnd_wdata", sram.data_sram_wdata, exp_wdata(op, rkd));
                lat = int'($urandom_range(0, 2));
                for (int k = 0; k < lat; k++) begin
                    tick();
                    chk1("rnd_req_hold", sram.data_sram_req, 1'b1);
                end
                sram.data_sram_addr_ok = 1'b1;
                tick();
                sram.data_sram_addr_ok = 1'b0;
                lat = int'($urandom_range(0, 2));
                for (int k = 0; k < lat; k++) tick();
                sram.data_sram_data_ok = 1'b1; sram.data_sram_rdata = rd;
                tick();
                sram.data_sram_data_ok = 1'b0;
                lat = int'($urandom_range(0, 3));
                WB_allowin = (lat == 0);
                #1;
                if (is_load(op)) begin
                    chk1("rnd_ld_fv", front_valid, 1'b1);
                    chk32("rnd_ld_fdata", front_data, expv);
                end
                for (int k = 0; k < lat; k++) begin
                    chk1("rnd_stall_allowin", MEM_allowin, 1'b0);
                    tick();
                end
                WB_allowin = 1'b1;
                tick();
            end
            chkw("rnd_wb", 128'(MEM_to_WB_reg), 128'({1'b1, pc, ir, ~is_store(op), wa, expv}));
            EX_to_MEM_zip = '0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
